// File: rtl/lsu_mem_initiator_pkg.sv
// Shared constants and state encoding for the load/store initiator and
// its address checker.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam int WORD_BYTES = 8;
    localparam int WORD_LSB   = $clog2(WORD_BYTES);
    localparam int IMM_W      = 9;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Request/response and RAM access-port bundle between the execute stage,
// the initiator and the word RAM.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; the requester holds all req_* fields stable until
// then. resp_valid is a one-cycle pulse with no backpressure, and it is the
// only qualifier for resp_rdata/resp_fault.
interface lsu_mem_initiator_if;
    import lsu_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [63:0]      req_base;
    logic [IMM_W-1:0] req_offset;
    logic [63:0]      req_wdata;
    logic             resp_valid;
    logic [63:0]      resp_rdata;
    logic             resp_fault;
    logic [63:0]      mem_address;
    logic             mem_read_en;
    logic             mem_write_en;
    logic [63:0]      mem_data_in;
    logic [63:0]      mem_out;
    state_t           dbg_state;

    modport master (
        input  req_valid, req_write, req_base, req_offset, req_wdata, mem_out,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_address, mem_read_en, mem_write_en, mem_data_in, dbg_state
    );

    modport slave (
        output req_valid, req_write, req_base, req_offset, req_wdata, mem_out,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mem_address, mem_read_en, mem_write_en, mem_data_in, dbg_state
    );

endinterface

// File: rtl/lsu_mem_initiator_ea_check.sv
// Effective-address generation and alignment/range check for imm9 accesses.
// Purely combinational so a pipelined LSU can reuse it per stage.
module ea_check
    import lsu_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic [63:0]      i_base,
    input  logic [IMM_W-1:0] i_offset,
    output logic [63:0]      o_ea,
    output logic [63:0]      o_index,
    output logic             o_fault
);

    // Wrapping add: negative offsets below zero land on huge indices and fault.
    assign o_ea    = i_base + {{(64-IMM_W){i_offset[IMM_W-1]}}, i_offset};
    assign o_index = o_ea >> WORD_LSB;
    assign o_fault = (|o_ea[WORD_LSB-1:0]) | (o_index >= 64'(DEPTH));

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: checks one request, holds the RAM enables for
// WAIT_CYCLES+1 cycles, then pulses a response.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    lsu_mem_initiator_if.master bus
);

    localparam logic [CNT_W-1:0] LP_WAIT = CNT_W'(WAIT_CYCLES);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_index;
    logic             r_write;
    logic [63:0]      r_wdata;
    logic [63:0]      r_rdata;
    logic             r_fault;
    logic             r_resp_valid;

    logic [63:0]      w_ea;
    logic [63:0]      w_index;
    logic             w_fault;
    logic             w_access;
    logic             w_unused;

    ea_check #(.DEPTH(DEPTH)) u_ea_check (
        .i_base   (bus.req_base),
        .i_offset (bus.req_offset),
        .o_ea     (w_ea),
        .o_index  (w_index),
        .o_fault  (w_fault)
    );

    assign w_unused = ^w_ea;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_index      <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_fault      <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        if (w_fault) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_fault      <= 1'b1;
                            r_rdata      <= '0;
                        end else begin
                            r_index <= w_index;
                            r_write <= bus.req_write;
                            r_wdata <= bus.req_wdata;
                            r_cnt   <= LP_WAIT;
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_rdata      <= r_write ? 64'd0 : bus.mem_out;
                        r_fault      <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RAM port decoded from state only, so reset drops enables without a clock.
    assign w_access         = (r_state == S_ACCESS);
    assign bus.req_ready    = (r_state == S_IDLE);
    assign bus.mem_address  = w_access ? r_index : 64'd0;
    assign bus.mem_read_en  = w_access & ~r_write;
    assign bus.mem_write_en = w_access & r_write;
    assign bus.mem_data_in  = (w_access & r_write) ? r_wdata : 64'd0;

    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_rdata   = r_rdata;
    assign bus.resp_fault   = r_fault;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a behavioural 32-word RAM.
module tb_lsu_mem_initiator;

    localparam int DEPTH = 32;
    localparam int WAIT  = 1;

    typedef struct {
        logic        wr;
        logic [63:0] base;
        logic [8:0]  off;
        logic [63:0] wdata;
        logic        fault;
        logic [63:0] idx;
        logic [63:0] rdata;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [63:0] ram [DEPTH];
    vec_t vecs [14];

    lsu_mem_initiator_if bus();

    lsu_mem_initiator #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read, write on the clock edge, reloaded in reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 64'hDEAD_BEEF_0000_0000 | 64'(i);
        end else if (bus.mem_write_en) begin
            ram[bus.mem_address[4:0]] <= bus.mem_data_in;
        end
    end

    always_comb begin
        bus.mem_out = 64'd0;
        if (bus.mem_read_en) bus.mem_out = ram[bus.mem_address[4:0]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic wr, input logic [63:0] base, input logic [8:0] off,
                             input logic [63:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_base   = base;
        bus.req_offset = off;
        bus.req_wdata  = wdata;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int g, lat, rd, wr, bad;
        logic [63:0] rdata;
        logic        fault;
        lat = 0; rd = 0; wr = 0; bad = 0; rdata = '0; fault = 1'b0;
        @(negedge clk);
        drive_req(v.wr, v.base, v.off, v.wdata);
        g = 0;
        while (!bus.req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
            if (bus.mem_read_en && bus.mem_write_en) bad++;
            if (bus.mem_read_en) begin
                rd++;
                if (bus.mem_address !== v.idx || bus.mem_data_in !== 64'd0) bad++;
            end
            if (bus.mem_write_en) begin
                wr++;
                if (bus.mem_address !== v.idx || bus.mem_data_in !== v.wdata) bad++;
            end
            if (bus.resp_valid) begin
                lat   = k;
                rdata = bus.resp_rdata;
                fault = bus.resp_fault;
            end
        end
        chk($sformatf("v%0d fault", n),   64'(fault), 64'(v.fault));
        chk($sformatf("v%0d rdata", n),   rdata, v.rdata);
        chk($sformatf("v%0d latency", n), 64'(lat), v.fault ? 64'd1 : 64'(WAIT + 2));
        chk($sformatf("v%0d rd_cycles", n), 64'(rd), (!v.fault && !v.wr) ? 64'(WAIT + 1) : 64'd0);
        chk($sformatf("v%0d wr_cycles", n), 64'(wr), (!v.fault && v.wr) ? 64'(WAIT + 1) : 64'd0);
        chk($sformatf("v%0d bus_errors", n), 64'(bad), 64'd0);
        @(negedge clk);
        chk($sformatf("v%0d single_pulse", n), 64'(bus.resp_valid), 64'd0);
        chk($sformatf("v%0d rdata_hold", n), bus.resp_rdata, v.rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1);
    end

    initial begin
        int rd, wr, ovl, first_wr, n_resp, resp_k1, resp_k2;
        logic [63:0] rdata1, rdata2;
        logic        fault2;

        n_checks = 0;
        n_fail   = 0;
        vecs[0]  = '{1'b0, 64'd40,  9'd0,     64'd0,   1'b0, 64'd5,  64'hDEAD_BEEF_0000_0005};
        vecs[1]  = '{1'b1, 64'd16,  9'd8,     64'h1234, 1'b0, 64'd3, 64'd0};
        vecs[2]  = '{1'b0, 64'd24,  9'd0,     64'd0,   1'b0, 64'd3,  64'h1234};
        vecs[3]  = '{1'b0, 64'd8,   9'd3,     64'd0,   1'b1, 64'd0,  64'd0};
        vecs[4]  = '{1'b0, 64'd248, 9'd8,     64'd0,   1'b1, 64'd0,  64'd0};
        vecs[5]  = '{1'b0, 64'd0,   9'h1F8,   64'd0,   1'b1, 64'd0,  64'd0};
        vecs[6]  = '{1'b0, 64'd256, 9'h1F8,   64'd0,   1'b0, 64'd31, 64'hDEAD_BEEF_0000_001F};
        vecs[7]  = '{1'b0, 64'd0,   9'd0,     64'd0,   1'b0, 64'd0,  64'hDEAD_BEEF_0000_0000};
        vecs[8]  = '{1'b1, 64'd100, 9'h1FC,   64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 64'd12, 64'd0};
        vecs[9]  = '{1'b0, 64'd96,  9'd0,     64'd0,   1'b0, 64'd12, 64'hA5A5_5A5A_0F0F_F0F0};
        vecs[10] = '{1'b1, 64'd1,   9'd1,     64'hFFFF, 1'b1, 64'd0, 64'd0};
        vecs[11] = '{1'b0, 64'd1,   9'h0FF,   64'd0,   1'b1, 64'd0,  64'd0};
        vecs[12] = '{1'b0, 64'd1,   9'h1FF,   64'd0,   1'b0, 64'd0,  64'hDEAD_BEEF_0000_0000};
        vecs[13] = '{1'b0, 64'd504, 9'h100,   64'd0,   1'b0, 64'd31, 64'hDEAD_BEEF_0000_001F};

        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_base = '0;
        bus.req_offset = '0;
        bus.req_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst mem_read_en",  64'(bus.mem_read_en), 64'd0);
        chk("rst mem_write_en", 64'(bus.mem_write_en), 64'd0);
        chk("rst mem_address",  bus.mem_address, 64'd0);
        chk("rst mem_data_in",  bus.mem_data_in, 64'd0);
        chk("rst resp_valid",   64'(bus.resp_valid), 64'd0);
        chk("rst resp_rdata",   bus.resp_rdata, 64'd0);
        chk("rst resp_fault",   64'(bus.resp_fault), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst req_ready", 64'(bus.req_ready), 64'd1);
        chk("post_rst state", 64'(bus.dbg_state), 64'(lsu_pkg::S_IDLE));

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Reset asserted in the second ACCESS cycle of a load
        @(negedge clk);
        drive_req(1'b0, 64'd40, 9'd0, 64'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("midrst read_en_before", 64'(bus.mem_read_en), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("midrst read_en_async", 64'(bus.mem_read_en), 64'd0);
        chk("midrst address_async", bus.mem_address, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_resp = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) chk("midrst req_ready", 64'(bus.req_ready), 64'd1);
            if (bus.resp_valid) n_resp++;
        end
        chk("midrst no_resp", 64'(n_resp), 64'd0);

        // Back-to-back load then store with req_valid held high
        rd = 0; wr = 0; ovl = 0; first_wr = 0; resp_k1 = 0; resp_k2 = 0;
        rdata1 = '0; rdata2 = '1; fault2 = 1'b1;
        @(negedge clk);
        drive_req(1'b0, 64'd40, 9'd0, 64'd0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.mem_read_en && bus.mem_write_en) ovl++;
            if (bus.mem_read_en) rd++;
            if (bus.mem_write_en) begin
                wr++;
                if (first_wr == 0) first_wr = k;
                if (bus.mem_address !== 64'd7 || bus.mem_data_in !== 64'hCAFE) ovl++;
            end
            if (bus.resp_valid) begin
                if (resp_k1 == 0) begin
                    resp_k1 = k;
                    rdata1  = bus.resp_rdata;
                end else begin
                    resp_k2 = k;
                    rdata2  = bus.resp_rdata;
                    fault2  = bus.resp_fault;
                end
            end
            if (k == 3) drive_req(1'b1, 64'd56, 9'd0, 64'hCAFE);
            if (k == 4) chk("b2b ready_after_resp", 64'(bus.req_ready), 64'd1);
            if (k == 5) bus.req_valid = 1'b0;
        end
        chk("b2b load_resp_cycle", 64'(resp_k1), 64'd3);
        chk("b2b load_rdata", rdata1, 64'hDEAD_BEEF_0000_0005);
        chk("b2b store_first_wr", 64'(first_wr), 64'd5);
        chk("b2b store_resp_cycle", 64'(resp_k2), 64'd7);
        chk("b2b store_rdata", rdata2, 64'd0);
        chk("b2b store_fault", 64'(fault2), 64'd0);
        chk("b2b rd_cycles", 64'(rd), 64'd2);
        chk("b2b wr_cycles", 64'(wr), 64'd2);
        chk("b2b overlap_or_bus", 64'(ovl), 64'd0);
        chk("b2b ram_word7", ram[7], 64'hCAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
